// File: rtl/digit_cell_scheduler_if.sv
// Host write channel into the digit cell RAM scheduler.
// Host holds req/addr/data until it sees the one-cycle ack.
interface digit_cell_scheduler_if #(
  parameter int ADDR_W = 12,
  parameter int CODE_W = 4
);
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [CODE_W-1:0] host_data;
  logic              host_ack;

  modport master (
    output host_req, host_addr, host_data,
    input  host_ack
  );

  modport slave (
    input  host_req, host_addr, host_data,
    output host_ack
  );
endinterface

// File: rtl/digit_cell_scheduler.sv
// Shares one single-port cell RAM between video prefetch and a host writer.
// Video reads the next cell ahead of the beam; the host gets every other slot.
module digit_cell_scheduler #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12,
  parameter int CODE_W = 4,
  parameter int H_AV   = 640,
  parameter int V_AV   = 480,
  parameter int V_LAST = 524,
  parameter int H_LAST = 799
) (
  input  logic              pix_clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              valid,
  digit_cell_scheduler_if.slave host,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [CODE_W-1:0] ram_wdata,
  input  logic [CODE_W-1:0] ram_rdata,
  output logic [CODE_W-1:0] glyph_code,
  output logic [3:0]        glyph_row,
  output logic [2:0]        glyph_col,
  output logic              glyph_valid
);

  localparam logic [9:0] HAV   = 10'(H_AV);
  localparam logic [9:0] VAV   = 10'(V_AV);
  localparam logic [9:0] VLAST = 10'(V_LAST);
  localparam logic [9:0] HLAST = 10'(H_LAST);
  localparam logic [6:0] NCOL  = 7'(COLS);
  localparam logic [5:0] NROW  = 6'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [CODE_W-1:0] BLANK  = '1;

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [CODE_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              host_ack_q, host_ack_d;
  logic              rd_pend_q, rd_pend_d;
  logic [CODE_W-1:0] cur_code_q, cur_code_d;
  logic [CODE_W-1:0] next_code_q, next_code_d;
  logic [CODE_W-1:0] glyph_code_q, glyph_code_d;
  logic [3:0]        glyph_row_q, glyph_row_d;
  logic [2:0]        glyph_col_q, glyph_col_d;
  logic              glyph_valid_q, glyph_valid_d;

  logic [9:0]        ny;
  logic [6:0]        xc1;
  logic              slot_a, slot_b, video_slot;
  logic              host_grant, swap;
  logic [ADDR_W-1:0] vaddr;

  always_comb begin
    ny     = (y == VLAST) ? 10'd0 : y + 10'd1;
    xc1    = x[9:3] + 7'd1;
    slot_a = (x < HAV) && (y < VAV) &&
             (x[2:0] == 3'd0) && (xc1 < NCOL);
    slot_b = (x == HAV) && (ny < VAV) &&
             (ny[9:4] < NROW);
    video_slot = slot_a | slot_b;
    // Row-start fetch targets column 0 of the next line's cell row
    if (slot_a)
      vaddr = ADDR_W'(y[9:4]) * COLS_A + ADDR_W'(xc1);
    else
      vaddr = ADDR_W'(ny[9:4]) * COLS_A;
    host_grant = host.host_req & ~video_slot & ~host_ack_q;
    swap = ((x < HAV) && (x[2:0] == 3'd7)) || (x == HLAST);
  end

  always_comb begin
    ram_en_d      = video_slot | host_grant;
    ram_we_d      = host_grant;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    host_ack_d    = host_grant;
    rd_pend_d     = ram_en_q & ~ram_we_q;
    next_code_d   = next_code_q;
    cur_code_d    = cur_code_q;
    glyph_code_d  = cur_code_q;
    glyph_row_d   = y[3:0];
    glyph_col_d   = x[2:0];
    glyph_valid_d = valid;
    unique case (1'b1)
      video_slot: ram_addr_d = vaddr;
      host_grant: begin
        ram_addr_d  = host.host_addr;
        ram_wdata_d = host.host_data;
      end
      default: ;
    endcase
    if (rd_pend_q) next_code_d = ram_rdata;
    if (swap)      cur_code_d  = next_code_q;
  end

  always_ff @(posedge pix_clk or negedge reset) begin
    if (!reset) begin
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      host_ack_q    <= 1'b0;
      rd_pend_q     <= 1'b0;
      cur_code_q    <= BLANK;
      next_code_q   <= BLANK;
      glyph_code_q  <= '0;
      glyph_row_q   <= '0;
      glyph_col_q   <= '0;
      glyph_valid_q <= 1'b0;
    end else begin
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      host_ack_q    <= host_ack_d;
      rd_pend_q     <= rd_pend_d;
      cur_code_q    <= cur_code_d;
      next_code_q   <= next_code_d;
      glyph_code_q  <= glyph_code_d;
      glyph_row_q   <= glyph_row_d;
      glyph_col_q   <= glyph_col_d;
      glyph_valid_q <= glyph_valid_d;
    end
  end

  assign ram_en        = ram_en_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign host.host_ack = host_ack_q;
  assign glyph_code    = glyph_code_q;
  assign glyph_row     = glyph_row_q;
  assign glyph_col     = glyph_col_q;
  assign glyph_valid   = glyph_valid_q;

endmodule

// File: tb/tb_digit_cell_scheduler.sv
// Directed bench for digit_cell_scheduler with a small RAM model.
// Beam position is driven by hand; expectations are hand-computed.
module tb_digit_cell_scheduler;

  logic        pix_clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        valid;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [3:0]  ram_wdata, ram_rdata;
  logic [3:0]  glyph_code;
  logic [3:0]  glyph_row;
  logic [2:0]  glyph_col;
  logic        glyph_valid;

  logic        ld_en;
  logic [11:0] ld_addr;
  logic [3:0]  ld_data;
  logic [3:0]  mem [0:4095];

  int n_chk  = 0;
  int n_fail = 0;

  digit_cell_scheduler_if #(.ADDR_W(12), .CODE_W(4)) hif ();

  digit_cell_scheduler dut (
    .pix_clk     (pix_clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .valid       (valid),
    .host        (hif),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .glyph_code  (glyph_code),
    .glyph_row   (glyph_row),
    .glyph_col   (glyph_col),
    .glyph_valid (glyph_valid)
  );

  always #5 pix_clk = ~pix_clk;

  always @(posedge pix_clk) begin
    if (ld_en)
      mem[ld_addr] <= ld_data;
    else if (ram_en && ram_we)
      mem[ram_addr] <= ram_wdata;
    else if (ram_en)
      ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic load(input int a, input int d);
    ld_en   = 1'b1;
    ld_addr = 12'(a);
    ld_data = 4'(d);
    @(posedge pix_clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic beam(input int xx, input int yy);
    x     = 10'(xx);
    y     = 10'(yy);
    valid = (xx < 640) && (yy < 480);
    @(posedge pix_clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    x = '0; y = '0; valid = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    hif.host_req  = 1'b0;
    hif.host_addr = '0;
    hif.host_data = '0;
    #1;
    load(0, 3);
    load(1, 7);
    load(2, 4);
    load(80, 1);
    load(81, 0);
    load(82, 9);
    check("rst_glyph_code", 32'(glyph_code), 0);
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_host_ack", 32'(hif.host_ack), 0);

    @(negedge pix_clk);
    reset = 1'b1;
    beam(700, 523);
    check("blank_after_rst", 32'(glyph_code), 32'hF);

    // Line-start prefetch of cell 0 during the last frame line
    beam(640, 524);
    check("wrap_en", 32'(ram_en), 1);
    check("wrap_we", 32'(ram_we), 0);
    check("wrap_addr", 32'(ram_addr), 0);
    for (int xx = 641; xx <= 799; xx++) beam(xx, 524);

    for (int xx = 0; xx < 16; xx++) begin
      beam(xx, 0);
      check($sformatf("code_x%0d", xx), 32'(glyph_code),
            (xx < 8) ? 32'd3 : 32'd7);
      check($sformatf("col_x%0d", xx), 32'(glyph_col),
            32'(xx % 8));
    end
    check("valid_active", 32'(glyph_valid), 1);

    beam(640, 479);
    check("no_fetch_479", 32'(ram_en), 0);
    check("row_479", 32'(glyph_row), 15);
    check("valid_blank", 32'(glyph_valid), 0);

    beam(640, 15);
    check("row1_fetch", 32'(ram_addr), 80);
    for (int xx = 641; xx <= 799; xx++) beam(xx, 15);
    for (int xx = 0; xx < 8; xx++) beam(xx, 16);

    // Host request collides with the video slot at x=8
    hif.host_req  = 1'b1;
    hif.host_addr = 12'd81;
    hif.host_data = 4'd5;
    beam(8, 16);
    check("coll_en", 32'(ram_en), 1);
    check("coll_we", 32'(ram_we), 0);
    check("coll_addr", 32'(ram_addr), 82);
    check("coll_ack", 32'(hif.host_ack), 0);
    beam(9, 16);
    check("host_ack", 32'(hif.host_ack), 1);
    check("host_we", 32'(ram_we), 1);
    check("host_addr", 32'(ram_addr), 81);
    check("host_wdata", 32'(ram_wdata), 5);
    beam(10, 16);
    check("no_regrant_ack", 32'(hif.host_ack), 0);
    check("no_regrant_en", 32'(ram_en), 0);
    check("hold_addr", 32'(ram_addr), 81);
    hif.host_req = 1'b0;
    for (int xx = 11; xx <= 16; xx++) beam(xx, 16);
    check("code_cell82", 32'(glyph_code), 9);
    check("mem81", 32'(mem[81]), 5);
    for (int xx = 17; xx <= 19; xx++) beam(xx, 16);

    // Reset lands between grant and ack
    x = 10'd20;
    hif.host_req  = 1'b1;
    hif.host_addr = 12'd100;
    hif.host_data = 4'd6;
    @(negedge pix_clk);
    reset = 1'b0;
    #1;
    check("midrst_ack", 32'(hif.host_ack), 0);
    check("midrst_en", 32'(ram_en), 0);
    check("midrst_addr", 32'(ram_addr), 0);
    check("midrst_valid", 32'(glyph_valid), 0);
    check("midrst_col", 32'(glyph_col), 0);
    @(posedge pix_clk);
    #1;
    check("rst_hold_ack", 32'(hif.host_ack), 0);
    check("rst_hold_we", 32'(ram_we), 0);
    x = 10'd21;
    @(negedge pix_clk);
    reset = 1'b1;
    @(posedge pix_clk);
    #1;
    check("regrant_ack", 32'(hif.host_ack), 1);
    check("regrant_we", 32'(ram_we), 1);
    check("regrant_addr", 32'(ram_addr), 100);
    check("regrant_wdata", 32'(ram_wdata), 6);
    check("regrant_blank", 32'(glyph_code), 32'hF);
    hif.host_req = 1'b0;
    beam(22, 16);
    check("single_ack", 32'(hif.host_ack), 0);
    beam(23, 16);
    check("mem100", 32'(mem[100]), 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
